// File: rtl/activation_engine.sv
// Chunked activation pipeline: round-and-shift requantisation followed by a
// selectable activation and output saturation, one UNROLL_FACTOR-wide chunk per cycle.
module activation_engine #(
    parameter int INPUT_SIZE    = 512,
    parameter int UNROLL_FACTOR = 8,
    parameter int IN_WIDTH      = 32,
    parameter int OUT_WIDTH     = 8,
    parameter int SHIFT         = 7,
    parameter int HT_LIMIT      = 127
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [1:0]                        mode,
    input  logic [INPUT_SIZE*IN_WIDTH-1:0]    inputs,
    output logic [INPUT_SIZE*OUT_WIDTH-1:0]   layer_out,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        fsm_state
);

    localparam int NUM_CHUNKS = INPUT_SIZE / UNROLL_FACTOR;
    localparam int CIW        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int RW         = IN_WIDTH + 1;
    localparam int RND_POS    = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [CIW-1:0]       LAST_CHUNK = CIW'(NUM_CHUNKS - 1);
    localparam logic signed [RW-1:0] ONE        = 1;
    localparam logic signed [RW-1:0] RND        = (SHIFT > 0) ? (ONE << RND_POS) : '0;
    localparam logic signed [RW-1:0] HT_P       = RW'(HT_LIMIT);
    localparam logic signed [RW-1:0] HT_N       = -HT_P;
    localparam logic signed [RW-1:0] OMAX       = RW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] OMIN       = ~OMAX;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    generate
        if (INPUT_SIZE % UNROLL_FACTOR != 0) begin : g_size_check
            $error("activation_engine: INPUT_SIZE must be a multiple of UNROLL_FACTOR");
        end
    endgenerate

    logic [1:0]              state;
    logic [CIW-1:0]          chunk_index;
    logic [1:0]              mode_q;
    logic                    s1_valid;
    logic [CIW-1:0]          s1_chunk;
    logic signed [RW-1:0]    s1_r   [UNROLL_FACTOR];
    logic signed [IN_WIDTH-1:0]  chunk_x [UNROLL_FACTOR];
    logic signed [OUT_WIDTH-1:0] act_y   [UNROLL_FACTOR];

    // One extra bit keeps x + 2^(SHIFT-1) from overflowing before the shift.
    function automatic logic signed [RW-1:0] requant(input logic signed [IN_WIDTH-1:0] x);
        logic signed [RW-1:0] xe;
        xe = {x[IN_WIDTH-1], x};
        return (xe + RND) >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] activate(input logic signed [RW-1:0] r,
                                                             input logic [1:0] m);
        logic signed [RW-1:0]        v;
        logic signed [OUT_WIDTH-1:0] y;
        case (m)
            2'd0: v = r;
            2'd1: v = r[RW-1] ? '0 : r;
            2'd2: begin
                if (r > HT_P)      v = HT_P;
                else if (r < HT_N) v = HT_N;
                else               v = r;
            end
            default: v = r[RW-1] ? (r >>> 3) : r;
        endcase
        if (v > OMAX)      y = OMAX[OUT_WIDTH-1:0];
        else if (v < OMIN) y = OMIN[OUT_WIDTH-1:0];
        else               y = v[OUT_WIDTH-1:0];
        return y;
    endfunction

    always_comb begin
        for (int j = 0; j < UNROLL_FACTOR; j++) chunk_x[j] = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (chunk_index == CIW'(c)) begin
                for (int j = 0; j < UNROLL_FACTOR; j++)
                    chunk_x[j] = inputs[(c*UNROLL_FACTOR + j)*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < UNROLL_FACTOR; j++) act_y[j] = activate(s1_r[j], mode_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            chunk_index <= '0;
            mode_q      <= 2'd0;
            s1_valid    <= 1'b0;
            s1_chunk    <= '0;
            done        <= 1'b0;
            for (int j = 0; j < UNROLL_FACTOR; j++) s1_r[j] <= '0;
        end else begin
            // done is registered off DONE so it rises as the FSM re-enters IDLE.
            done     <= (state == S_DONE);
            s1_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        chunk_index <= '0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    s1_valid <= 1'b1;
                    s1_chunk <= chunk_index;
                    for (int j = 0; j < UNROLL_FACTOR; j++) s1_r[j] <= requant(chunk_x[j]);
                    if (chunk_index == LAST_CHUNK) state <= S_DRAIN;
                    else                           chunk_index <= chunk_index + 1'b1;
                end
                S_DRAIN: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_out <= '0;
        end else if (s1_valid) begin
            for (int c = 0; c < NUM_CHUNKS; c++) begin
                if (s1_chunk == CIW'(c)) begin
                    for (int j = 0; j < UNROLL_FACTOR; j++)
                        layer_out[(c*UNROLL_FACTOR + j)*OUT_WIDTH +: OUT_WIDTH] <= act_y[j];
                end
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_activation_engine.sv
// Directed bench for activation_engine: 16 elements in two chunks, hand-computed
// expected outputs for every mode plus timing, restart, reset and back-to-back runs.
module tb_activation_engine;

    localparam int N  = 16;
    localparam int U  = 8;
    localparam int IW = 32;
    localparam int OW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [N*IW-1:0]   inputs = '0;
    logic [N*OW-1:0]   layer_out;
    logic              busy;
    logic              done;
    logic [1:0]        fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [OW-1:0] exp_q[$];

    // x values chosen to hit rounding ties, saturation and each activation branch.
    longint vec_v [N] = '{64, 63, -65, 1073741824, -1073741824, -1000, -1024, 20000,
                          -20000, 256, -256, 0, 12800, 12928, -12800, -12928};
    // Rows: PASS, RELU, HARDTANH (limit 100), LEAKY.
    longint exp_tab [4][N] = '{
        '{1, 0, -1, 127, -128, -8, -8, 127, -128, 2, -2, 0, 100, 101, -100, -101},
        '{1, 0,  0, 127,    0,  0,  0, 127,    0, 2,  0, 0, 100, 101,    0,    0},
        '{1, 0, -1, 100, -100, -8, -8, 100, -100, 2, -2, 0, 100, 100, -100, -100},
        '{1, 0, -1, 127, -128, -1, -1, 127,  -20, 2, -1, 0, 100, 101,  -13,  -13}
    };

    activation_engine #(
        .INPUT_SIZE(N), .UNROLL_FACTOR(U), .IN_WIDTH(IW), .OUT_WIDTH(OW),
        .SHIFT(7), .HT_LIMIT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .inputs(inputs),
        .layer_out(layer_out), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint out_at(input int i);
        logic signed [OW-1:0] v;
        v = layer_out[i*OW +: OW];
        return longint'(v);
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < N; i++) inputs[i*IW +: IW] = IW'(i * 256);
    endtask

    task automatic load_vec();
        longint v;
        for (int i = 0; i < N; i++) begin
            v = vec_v[i];
            inputs[i*IW +: IW] = v[IW-1:0];
        end
    endtask

    task automatic expect_row(input int m);
        longint v;
        for (int i = 0; i < N; i++) begin
            v = exp_tab[m][i];
            exp_q.push_back(v[OW-1:0]);
        end
    endtask

    task automatic expect_ramp();
        for (int i = 0; i < N; i++) exp_q.push_back(OW'(2 * i));
    endtask

    task automatic compare_outputs(input string tag);
        logic signed [OW-1:0] e;
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), out_at(i), longint'(e));
        end
    endtask

    // Called at a negedge; the following posedge is the start edge E0.
    // Sample c is taken at the negedge after edge E0+c.
    task automatic run_once(input logic [1:0] m, input bit glitch,
                            output int lat, output int busy_cnt, output int done_cnt);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = c;
            end
            if (glitch && c == 1) begin
                start = 1'b1;
                mode  = ~m;
            end
            if (glitch && c == 2) start = 1'b0;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;
        int d_at[$];
        string names [4] = '{"pass", "relu", "htanh", "leaky"};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", fsm_state, 0);
        check("reset_out_zero", (layer_out == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp in PASS mode: latency and busy length for two chunks.
        load_ramp();
        run_once(2'd0, 1'b0, lat, bcnt, dcnt);
        check("ramp_latency", lat, 4);
        check("ramp_busy_cycles", bcnt, 4);
        check("ramp_done_count", dcnt, 1);
        expect_ramp();
        compare_outputs("ramp");

        // Same vector through each activation.
        load_vec();
        for (int m = 0; m < 4; m++) begin
            run_once(2'(m), 1'b0, lat, bcnt, dcnt);
            check({names[m], "_latency"}, lat, 4);
            check({names[m], "_done_count"}, dcnt, 1);
            expect_row(m);
            compare_outputs(names[m]);
        end

        // start re-pulsed and mode changed mid-run must not restart or alter results.
        run_once(2'd1, 1'b1, lat, bcnt, dcnt);
        check("glitch_latency", lat, 4);
        check("glitch_busy_cycles", bcnt, 4);
        check("glitch_done_count", dcnt, 1);
        expect_row(1);
        compare_outputs("glitch_relu");

        // Reset on cycle 2 of a run.
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_zero", (layer_out == '0), 1);
        check("midrst_busy", busy, 0);
        check("midrst_state", fsm_state, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        check("midrst_idle", busy, 0);
        run_once(2'd0, 1'b0, lat, bcnt, dcnt);
        check("after_rst_latency", lat, 4);
        check("after_rst_done_count", dcnt, 1);
        expect_row(0);
        compare_outputs("after_rst");

        // start held high: runs back to back, done every NUM_CHUNKS+3 cycles.
        load_ramp();
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) d_at.push_back(c);
            if (c == 19) start = 1'b0;
        end
        check("b2b_done_count", d_at.size(), 4);
        if (d_at.size() >= 3) begin
            check("b2b_first_done", d_at[0], 4);
            check("b2b_period_1", d_at[1] - d_at[0], 5);
            check("b2b_period_2", d_at[2] - d_at[1], 5);
        end else begin
            check("b2b_enough_dones", d_at.size(), 3);
        end
        repeat (6) @(negedge clk);
        check("b2b_idle", busy, 0);
        expect_ramp();
        compare_outputs("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/activation_engine.md
ACTIVATION_ENGINE -- requirements
Module: activation_engine

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 512, number of elements in the input and output vectors.
REQ-002 SHALL have parameter UNROLL_FACTOR, default 8, elements processed per chunk.
REQ-003 SHALL have parameter IN_WIDTH, default 32, signed input element width.
REQ-004 SHALL have parameter OUT_WIDTH, default 8, signed output element width.
REQ-005 SHALL have parameter SHIFT, default 7, requantisation right-shift amount, range 0..IN_WIDTH-1.
REQ-006 SHALL have parameter HT_LIMIT, default 127, hard-tanh clamp magnitude, at most 2^(OUT_WIDTH-1)-1.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-009 SHALL have port start, input, 1, request to process the vector; acted on only in IDLE.
REQ-010 SHALL have port mode, input, 2, activation select: 0 PASS, 1 RELU, 2 HARDTANH, 3 LEAKY.
REQ-011 SHALL have port inputs, input, INPUT_SIZE x IN_WIDTH signed, the input vector.
REQ-012 SHALL have port layer_out, output, OUTPUT_SIZE=INPUT_SIZE x OUT_WIDTH signed, the registered result vector.
REQ-013 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL be a FSM with states IDLE, RUN, DRAIN and DONE.
REQ-016 SHALL, in IDLE with start high at edge E0, latch mode, clear chunk_index to 0 and enter RUN.
REQ-017 SHALL, in RUN, move chunk k (elements k*UNROLL_FACTOR .. k*UNROLL_FACTOR+UNROLL_FACTOR-1) into pipeline stage 1 at edge E0+1+k, one chunk per cycle with no stalls.
REQ-018 SHALL, in stage 1, compute r = (x + 2^(SHIFT-1)) >>> SHIFT in IN_WIDTH+1 bits (arithmetic shift, no overflow), with r = x when SHIFT=0.
REQ-019 SHALL, in stage 2, apply the latched mode to r as follows: PASS r; RELU max(r,0); HARDTANH clamp to [-HT_LIMIT, HT_LIMIT]; LEAKY r when r>=0, else r>>>3 (floor).
REQ-020 SHALL saturate the stage-2 result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and write it to layer_out at edge E0+2+k.
REQ-021 SHALL go from RUN to DRAIN after the edge that issues chunk NUM_CHUNKS-1, then from DRAIN to DONE once that chunk is written.
REQ-022 SHALL drive done high for exactly one cycle starting at edge E0+NUM_CHUNKS+2, then return to IDLE.
REQ-023 SHALL hold layer_out elements that have not yet been written at their previous values.
REQ-024 SHALL ignore start in RUN, DRAIN and DONE; start still high in IDLE after DONE SHALL launch a new run.
REQ-025 SHALL ignore changes on mode while busy.
REQ-026 SHALL sample inputs per chunk at issue time; the source keeps inputs stable while busy.
REQ-027 SHALL work for NUM_CHUNKS = 1 (RUN lasts one cycle) and SHALL fail elaboration if INPUT_SIZE is not a multiple of UNROLL_FACTOR.

Reset
REQ-028 SHALL, with rst_n low, immediately force state IDLE, chunk_index 0, pipeline valids 0, done 0, busy 0, every layer_out element 0 and latched mode 0.
REQ-029 SHALL, on reset asserted mid-run, abandon the run with no done pulse; the first start after rst_n rises SHALL begin a full new run.

Verification
REQ-030 SHALL cover: INPUT_SIZE=16, UNROLL=8, SHIFT=7, mode PASS, inputs[i]=i*256 -> layer_out[i]=min(2i,127), done exactly 4 cycles after the start edge, busy high for 4 cycles.
REQ-031 SHALL cover: mode RELU, x=-1000 -> 0; mode LEAKY, x=-1024 -> -1; mode HARDTANH, HT_LIMIT=100, x=20000 -> 100; x=-20000 -> -100.
REQ-032 SHALL cover rounding and saturation: SHIFT=7, x=64 -> 1; x=63 -> 0; x=-65 -> -1; x=2^30 -> 127; x=-2^30 -> -128.
REQ-033 SHALL cover: start pulsed again and mode changed while busy -> no restart, results use the original mode, single done pulse.
REQ-034 SHALL cover: rst_n low on cycle 2 of a run -> layer_out all 0 asynchronously, no done; a new start then completes normally.
REQ-035 SHALL cover: start held high continuously -> back-to-back runs, done every NUM_CHUNKS+3 cycles.
